// File: rtl/noc_pkg.sv
// Shared constants and FSM encoding for the router input-port controller.
package noc_pkg;
    localparam int FLIT_W  = 40;
    localparam int COORD_W = 3;
    localparam int NPORTS  = 5;

    localparam int P_N = 0;
    localparam int P_E = 1;
    localparam int P_S = 2;
    localparam int P_W = 3;
    localparam int P_L = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_LATCH,
        ST_REQ,
        ST_SEND
    } state_e;
endpackage

// File: rtl/noc_xy_route.sv
// Combinational dimension-ordered (X then Y) route decode to a one-hot output port.
module noc_xy_route #(
    parameter int COORD_W = noc_pkg::COORD_W,
    parameter int CUR_X   = 0,
    parameter int CUR_Y   = 0
) (
    input  logic [COORD_W-1:0] dst_x_i,
    input  logic [COORD_W-1:0] dst_y_i,
    output logic [4:0]         route_o
);
    import noc_pkg::*;

    localparam logic [COORD_W-1:0] CX = COORD_W'(CUR_X);
    localparam logic [COORD_W-1:0] CY = COORD_W'(CUR_Y);

    always_comb begin
        route_o = '0;
        if (dst_x_i > CX)
            route_o[P_E] = 1'b1;
        else if (dst_x_i < CX)
            route_o[P_W] = 1'b1;
        else if (dst_y_i > CY)
            route_o[P_N] = 1'b1;
        else if (dst_y_i < CY)
            route_o[P_S] = 1'b1;
        else
            route_o[P_L] = 1'b1;
    end
endmodule

// File: rtl/noc_input_port_ctrl.sv
// Drains one input FIFO a single-flit packet at a time, requests the XY output
// port from the arbiter and forwards the flit to the crossbar on grant.
module noc_input_port_ctrl #(
    parameter int FLIT_W  = noc_pkg::FLIT_W,
    parameter int COORD_W = noc_pkg::COORD_W,
    parameter int CUR_X   = 0,
    parameter int CUR_Y   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic              fifo_wr,
    output logic              fifo_rd,
    input  logic [FLIT_W-1:0] fifo_data,
    output logic              req,
    output logic [4:0]        route,
    input  logic              grant,
    output logic [FLIT_W-1:0] out_data,
    output logic              out_valid
);
    import noc_pkg::*;

    state_e            state_q, state_d;
    logic [FLIT_W-1:0] flit_q;
    logic [4:0]        route_q;
    logic [4:0]        xy_route;
    logic [COORD_W-1:0] dst_x, dst_y;

    assign dst_x = fifo_data[FLIT_W-1 -: COORD_W];
    assign dst_y = fifo_data[FLIT_W-1-COORD_W -: COORD_W];

    noc_xy_route #(
        .COORD_W (COORD_W),
        .CUR_X   (CUR_X),
        .CUR_Y   (CUR_Y)
    ) u_xy_route (
        .dst_x_i (dst_x),
        .dst_y_i (dst_y),
        .route_o (xy_route)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // FIFO read data is valid only in the cycle after an accepted pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flit_q  <= '0;
            route_q <= '0;
        end else if (state_q == ST_LATCH) begin
            flit_q  <= fifo_data;
            route_q <= xy_route;
        end
    end

    always_comb begin
        state_d   = state_q;
        fifo_rd   = 1'b0;
        req       = 1'b0;
        route     = '0;
        out_valid = 1'b0;
        out_data  = '0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty)
                    state_d = ST_POP;
            end
            ST_POP: begin
                fifo_rd = 1'b1;
                // The FIFO drops a read that coincides with a write; retry.
                if (!fifo_wr)
                    state_d = ST_LATCH;
            end
            ST_LATCH: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                req   = 1'b1;
                route = route_q;
                if (grant)
                    state_d = ST_SEND;
            end
            ST_SEND: begin
                out_valid = 1'b1;
                out_data  = flit_q;
                state_d   = fifo_empty ? ST_IDLE : ST_POP;
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_noc_input_port_ctrl.sv
// Bench for noc_input_port_ctrl: FIFO model, route table, directed corners and random traffic.
module tb_noc_input_port_ctrl;
    localparam int FW = 40;
    localparam int CW = 3;
    localparam int CX = 2;
    localparam int CY = 2;

    logic          clk = 1'b0;
    logic          rst, fifo_empty, fifo_wr, fifo_rd, req, grant, out_valid;
    logic [FW-1:0] fifo_data, out_data;
    logic [4:0]    route;

    always #5 clk = ~clk;

    noc_input_port_ctrl #(
        .FLIT_W  (FW),
        .COORD_W (CW),
        .CUR_X   (CX),
        .CUR_Y   (CY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_wr    (fifo_wr),
        .fifo_rd    (fifo_rd),
        .fifo_data  (fifo_data),
        .req        (req),
        .route      (route),
        .grant      (grant),
        .out_data   (out_data),
        .out_valid  (out_valid)
    );

    typedef struct {
        int         dx;
        int         dy;
        logic [4:0] exp_route;
    } vec_t;

    vec_t          tbl[10];
    int            n_vec = 0;
    int            n_err = 0;
    logic [FW-1:0] fifo_q[$];
    logic [FW-1:0] sb_q[$];
    int            ov_cyc[$];
    bit            wr_push_en;
    int            k, rd_cnt, req_cnt, ov_cnt, first_rd, first_req, first_ov;
    logic [4:0]    last_req_route;

    function automatic logic [4:0] xy_ref(int dx, int dy);
        if (dx > CX) return 5'b00010;
        if (dx < CX) return 5'b01000;
        if (dy > CY) return 5'b00001;
        if (dy < CY) return 5'b00100;
        return 5'b10000;
    endfunction

    function automatic logic [4:0] ref_of(logic [FW-1:0] f);
        return xy_ref(int'(f[FW-1 -: CW]), int'(f[FW-1-CW -: CW]));
    endfunction

    function automatic logic [FW-1:0] mk_flit(int dx, int dy);
        logic [63:0]   r;
        logic [FW-1:0] f;
        r = {$urandom(), $urandom()};
        f = r[FW-1:0];
        f[FW-1 -: CW]    = dx[CW-1:0];
        f[FW-1-CW -: CW] = dy[CW-1:0];
        return f;
    endfunction

    task automatic chk(string nm, logic [FW-1:0] act, logic [FW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push(logic [FW-1:0] f);
        fifo_q.push_back(f);
        sb_q.push_back(f);
        fifo_empty = 1'b0;
    endtask

    task automatic clr();
        k = 0; rd_cnt = 0; req_cnt = 0; ov_cnt = 0;
        first_rd = -1; first_req = -1; first_ov = -1;
        last_req_route = '0;
        ov_cyc.delete();
    endtask

    // One clock: check outputs at negedge, then advance the FIFO model after the edge.
    task automatic cycle();
        bit do_pop, do_wr;
        @(negedge clk);
        chk("rd_while_empty", FW'(fifo_rd & fifo_empty), '0);
        if (fifo_rd) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = k;
            chk("route_in_pop", FW'(route), '0);
        end
        if (req) begin
            req_cnt++;
            if (first_req < 0) first_req = k;
            last_req_route = route;
            chk("req_onehot", FW'($countones(route)), FW'(1));
            if (sb_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL req_no_flit: got req=1, expected no pending flit to request");
            end else
                chk("req_route", FW'(route), FW'(ref_of(sb_q[0])));
        end
        if (out_valid) begin
            ov_cnt++;
            ov_cyc.push_back(k);
            if (first_ov < 0) first_ov = k;
            if (sb_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL spurious_out_valid: got data 0x%0h, expected no output", out_data);
            end else
                chk("out_data", out_data, sb_q.pop_front());
        end
        do_pop = fifo_rd && !fifo_wr && (fifo_q.size() > 0);
        do_wr  = fifo_wr && wr_push_en;
        @(posedge clk);
        #1;
        if (do_pop) fifo_data = fifo_q.pop_front();
        if (do_wr) push(mk_flit(int'($urandom_range(0, 7)), int'($urandom_range(0, 7))));
        fifo_empty = (fifo_q.size() == 0);
        k++;
    endtask

    initial begin
        tbl[0] = '{5, 2, 5'b00010};
        tbl[1] = '{0, 2, 5'b01000};
        tbl[2] = '{2, 4, 5'b00001};
        tbl[3] = '{2, 0, 5'b00100};
        tbl[4] = '{2, 2, 5'b10000};
        tbl[5] = '{7, 0, 5'b00010};
        tbl[6] = '{1, 7, 5'b01000};
        tbl[7] = '{2, 7, 5'b00001};
        tbl[8] = '{3, 3, 5'b00010};
        tbl[9] = '{2, 1, 5'b00100};

        rst = 1'b1; fifo_empty = 1'b1; fifo_wr = 1'b0; grant = 1'b0;
        fifo_data = '0; wr_push_en = 1'b0;

        // Reset and idle with an empty FIFO.
        for (int i = 0; i < 10; i++) begin
            rst = (i < 3);
            @(negedge clk);
            chk("rst_fifo_rd", FW'(fifo_rd), '0);
            chk("rst_req", FW'(req), '0);
            chk("rst_route", FW'(route), '0);
            chk("rst_out_valid", FW'(out_valid), '0);
            chk("rst_out_data", out_data, '0);
            @(posedge clk);
            #1;
        end

        // Route table, one flit each, grant tied high.
        for (int i = 0; i < 10; i++) begin
            clr();
            grant = 1'b1;
            push(mk_flit(tbl[i].dx, tbl[i].dy));
            while (ov_cnt == 0 && k < 20) cycle();
            repeat (2) cycle();
            chk("tbl_route", FW'(last_req_route), FW'(tbl[i].exp_route));
            chk("tbl_ov_count", FW'(ov_cnt), FW'(1));
            chk("tbl_rd_cycle", FW'(first_rd), FW'(1));
            chk("tbl_req_cycle", FW'(first_req), FW'(3));
            chk("tbl_ov_cycle", FW'(first_ov), FW'(4));
        end

        // Write contention during POP for 3 cycles.
        clr();
        grant = 1'b1;
        push(mk_flit(6, 1));
        for (int i = 0; i < 12; i++) begin
            fifo_wr = (i >= 1 && i <= 3);
            cycle();
        end
        fifo_wr = 1'b0;
        chk("wr_rd_cycles", FW'(rd_cnt), FW'(4));
        chk("wr_ov_count", FW'(ov_cnt), FW'(1));
        chk("wr_ov_cycle", FW'(first_ov), FW'(7));
        chk("wr_fifo_left", FW'(fifo_q.size()), '0);

        // Grant withheld for 7 REQ cycles.
        clr();
        push(mk_flit(2, 5));
        for (int i = 0; i < 16; i++) begin
            grant = (i >= 10);
            cycle();
        end
        chk("hold_req_cycles", FW'(req_cnt), FW'(8));
        chk("hold_ov_count", FW'(ov_cnt), FW'(1));
        chk("hold_ov_cycle", FW'(first_ov), FW'(11));

        // Eight queued flits back to back.
        clr();
        grant = 1'b1;
        for (int i = 0; i < 8; i++)
            push(mk_flit(int'($urandom_range(0, 7)), int'($urandom_range(0, 7))));
        for (int i = 0; i < 40; i++) cycle();
        chk("b2b_ov_count", FW'(ov_cnt), FW'(8));
        chk("b2b_first_ov", FW'(first_ov), FW'(4));
        for (int i = 1; i < ov_cyc.size(); i++)
            chk("b2b_spacing", FW'(ov_cyc[i] - ov_cyc[i-1]), FW'(4));

        // Reset while requesting.
        clr();
        grant = 1'b0;
        push(mk_flit(0, 0));
        for (int i = 0; i < 4; i++) cycle();
        chk("rstreq_seen", FW'(first_req), FW'(3));
        rst = 1'b1;
        #1;
        chk("rstreq_req", FW'(req), '0);
        chk("rstreq_route", FW'(route), '0);
        chk("rstreq_out_valid", FW'(out_valid), '0);
        chk("rstreq_out_data", out_data, '0);
        chk("rstreq_fifo_rd", FW'(fifo_rd), '0);
        sb_q.delete();
        repeat (2) cycle();
        rst = 1'b0;
        grant = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        chk("rstreq_no_ov", FW'(ov_cnt), '0);
        chk("rstreq_req_total", FW'(req_cnt), FW'(1));

        // Random traffic with random grants and write contention.
        clr();
        wr_push_en = 1'b1;
        for (int i = 0; i < 800; i++) begin
            grant   = ($urandom_range(0, 3) != 0);
            fifo_wr = ($urandom_range(0, 4) == 0);
            cycle();
        end
        fifo_wr = 1'b0;
        wr_push_en = 1'b0;
        grant = 1'b1;
        for (int i = 0; i < 400 && sb_q.size() > 0; i++) cycle();
        repeat (4) cycle();
        chk("rand_undelivered", FW'(sb_q.size()), '0);
        chk("rand_fifo_left", FW'(fifo_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
